dmem_responder: RTL

- Multi-cycle data-memory responder: the target side of the pipeline's MEM-stage load/store request interface (read enable, write enable, byte address, write data, funct3).
- Serves requests from an internal byte-addressable, little-endian word array after a configurable number of wait states.
- Signals `stall` to the pipeline, which must freeze its stages while `stall` is high, and returns load data with RV32I sub-word extension.
- Flags misaligned or illegal-width accesses.

---
 rtl/dmem_responder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module  : dmem_responder
// Purpose : Multi-cycle data-memory target for the MEM stage; stalls the
//           pipeline for WAIT_CYCLES wait states, then stores or returns RV32I
//           extended load data, flagging misaligned or illegal accesses.
// Revision: 1.0 - initial release
// ============================================================================
module dmem_responder #(
    parameter int DM_ADDRESS  = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_rd,
    input  logic                  req_wr,
    input  logic [DM_ADDRESS-1:0] req_addr,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  stall,
    output logic [DATA_W-1:0]     rdata,
    output logic                  rvalid,
    output logic                  err
);

    localparam int         c_DEPTH     = 2 ** (DM_ADDRESS - 2);
    localparam logic [3:0] c_WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    logic [3:0]              r_cnt;
    logic [DM_ADDRESS-1:0]   r_addr;
    logic [DATA_W-1:0]       r_wdata;
    logic [2:0]              r_funct3;
    logic                    r_is_wr;
    logic [DATA_W-1:0]       r_rdata;
    logic                    r_rvalid;
    logic                    r_err;
    logic [DATA_W-1:0]       r_mem [0:c_DEPTH-1];

    logic                    w_req;
    logic                    w_idle;
    logic [DM_ADDRESS-1:0]   w_addr;
    logic [DATA_W-1:0]       w_wdata;
    logic [2:0]              w_funct3;
    logic                    w_is_wr;
    logic [1:0]              w_lane;
    logic                    w_commit;
    logic                    w_err;
    logic                    w_we;
    logic [DATA_W-1:0]       w_word;
    logic [7:0]              w_byte;
    logic [15:0]             w_half;
    logic [DATA_W-1:0]       w_load;
    logic [3:0]              w_be;
    logic [DATA_W-1:0]       w_wlanes;

    assign w_req  = req_rd | req_wr;
    assign w_idle = (r_state == S_IDLE);

    // In IDLE the live request is used so a zero-wait build can commit at once
    assign w_addr   = w_idle ? req_addr   : r_addr;
    assign w_wdata  = w_idle ? req_wdata  : r_wdata;
    assign w_funct3 = w_idle ? req_funct3 : r_funct3;
    assign w_is_wr  = w_idle ? req_wr     : r_is_wr;
    assign w_lane   = w_addr[1:0];

    assign w_commit = (w_idle && w_req && (WAIT_CYCLES == 0)) ||
                      ((r_state == S_WAIT) && (r_cnt == 4'd0));
    assign stall    = (w_idle && w_req) || (r_state == S_WAIT);
    assign w_we     = w_commit & w_is_wr & ~w_err & ~reset;

    assign w_word = r_mem[w_addr[DM_ADDRESS-1:2]];
    assign w_byte = w_word[8*w_lane +: 8];
    assign w_half = w_lane[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        w_err = 1'b1;
        case (w_funct3)
            3'b000:         w_err = 1'b0;
            3'b001:         w_err = w_lane[0];
            3'b010:         w_err = |w_lane;
            3'b100, 3'b101: w_err = w_is_wr | (w_funct3[0] & w_lane[0]);
            default:        w_err = 1'b1;
        endcase
    end

    always_comb begin
        w_load   = w_word;
        w_be     = 4'b1111;
        w_wlanes = w_wdata;
        case (w_funct3[1:0])
            2'b00: begin
                w_load   = {{24{~w_funct3[2] & w_byte[7]}}, w_byte};
                w_be     = 4'b0001 << w_lane;
                w_wlanes = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_load   = {{16{~w_funct3[2] & w_half[15]}}, w_half};
                w_be     = w_lane[1] ? 4'b1100 : 4'b0011;
                w_wlanes = {2{w_wdata[15:0]}};
            end
            default: begin
                w_load   = w_word;
                w_be     = 4'b1111;
                w_wlanes = w_wdata;
            end
        endcase
    end

    // Array is intentionally left out of reset
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (w_we && w_be[i]) begin
                r_mem[w_addr[DM_ADDRESS-1:2]][8*i +: 8] <= w_wlanes[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 4'd0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_funct3 <= 3'd0;
            r_is_wr  <= 1'b0;
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            if (w_commit) begin
                r_err    <= w_err;
                r_rvalid <= ~w_is_wr & ~w_err;
                if (!w_is_wr && !w_err) begin
                    r_rdata <= w_load;
                end
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_funct3 <= req_funct3;
                        r_is_wr  <= req_wr;
                        r_cnt    <= c_WAIT_INIT;
                        r_state  <= (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rdata  = r_rdata;
    assign rvalid = r_rvalid;
    assign err    = r_err;

endmodule
`default_nettype wire
